// File: rtl/adc_avg_sampler.sv
// adc_avg_sampler
//   Front-end sampler between the SAR ADC macro and the digital top. A rising
//   edge on APP_START launches 1/2/4/8 conversions (2**AVG_SEL), the results
//   are summed and the truncated mean is presented on ADC_PI with APP_DONE.
//   A conversion that never reports ADC_EOC ends the run with TIMEOUT_ERR.
//
// Ports
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   APP_START    level request; rising edge starts, low releases/aborts
//   AVG_SEL      log2 of sample count, captured at start
//   ADC_EOC      end-of-conversion strobe (one cycle)
//   ADC_DOUT     conversion result, valid with ADC_EOC
//   ADC_SOC      registered one-cycle start-of-conversion pulse
//   ADC_PI       registered averaged result
//   APP_DONE     registered done level
//   TIMEOUT_ERR  sticky timeout flag, cleared by the next start or reset
//
// state  | meaning
// S_IDLE | waiting for a rising edge on APP_START
// S_SOC  | ADC_SOC high for this single cycle, timeout counter cleared
// S_WAIT | waiting for ADC_EOC, accumulating, counting timeout
// S_AVG  | all samples in; load the shifted sum into ADC_PI
// S_DONE | result/flags held until APP_START falls

module adc_avg_sampler #(
  parameter int ADC_WIDTH    = 10,
  parameter int MAX_LOG2_AVG = 3,
  parameter int CONV_TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 APP_START,
  input  logic [1:0]           AVG_SEL,
  input  logic                 ADC_EOC,
  input  logic [ADC_WIDTH-1:0] ADC_DOUT,
  output logic                 ADC_SOC,
  output logic [ADC_WIDTH-1:0] ADC_PI,
  output logic                 APP_DONE,
  output logic                 TIMEOUT_ERR
);

  localparam int ACC_W = ADC_WIDTH + MAX_LOG2_AVG;
  localparam int CNT_W = MAX_LOG2_AVG + 1;
  localparam int TMO_W = $clog2(CONV_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOC,
    S_WAIT,
    S_AVG,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 start_prev_q, start_prev_d;
  logic [1:0]           n_q, n_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 soc_q, soc_d;
  logic [ADC_WIDTH-1:0] pi_q, pi_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 start_edge;

  assign start_edge = APP_START & ~start_prev_q;

  always_comb begin
    state_d      = state_q;
    start_prev_d = APP_START;
    n_d          = n_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    soc_d        = 1'b0;
    pi_d         = pi_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start_edge) begin
          n_d     = AVG_SEL;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          soc_d   = 1'b1;
          state_d = S_SOC;
        end
      end

      S_SOC: begin
        if (!APP_START) begin
          state_d = S_IDLE;
        end else begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!APP_START) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (ADC_EOC) begin
            acc_d = acc_q + ACC_W'(ADC_DOUT);
            cnt_d = cnt_q + CNT_W'(1);
            if ((cnt_q + CNT_W'(1)) == (CNT_W'(1) << n_q)) begin
              state_d = S_AVG;
            end else begin
              soc_d   = 1'b1;
              state_d = S_SOC;
            end
          end else if (tmo_q == TMO_W'(CONV_TIMEOUT - 1)) begin
            // Timeout ends the run as "done with error"; ADC_PI is left alone.
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_AVG: begin
        if (!APP_START) begin
          state_d = S_IDLE;
        end else begin
          pi_d    = ADC_WIDTH'(acc_q >> n_q);
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (!APP_START) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      // A request level held high across reset is not a fresh request; the
      // edge detector comes out of reset as if the level was already seen.
      start_prev_q <= 1'b1;
      n_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      soc_q        <= 1'b0;
      pi_q         <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      n_q          <= n_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      soc_q        <= soc_d;
      pi_q         <= pi_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign ADC_SOC     = soc_q;
  assign ADC_PI      = pi_q;
  assign APP_DONE    = done_q;
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_adc_avg_sampler.sv
module tb_adc_avg_sampler;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       APP_START = 1'b0;
  logic [1:0] AVG_SEL = 2'd0;
  logic       ADC_EOC = 1'b0;
  logic [9:0] ADC_DOUT = 10'd0;
  logic       ADC_SOC;
  logic [9:0] ADC_PI;
  logic       APP_DONE;
  logic       TIMEOUT_ERR;

  int checks = 0;
  int errors = 0;
  int soc_count = 0;
  int soc_wide = 0;
  logic soc_prev = 1'b0;
  logic [9:0] exp_pi = 10'd0;

  adc_avg_sampler dut (
    .CLK        (CLK),
    .RST        (RST),
    .APP_START  (APP_START),
    .AVG_SEL    (AVG_SEL),
    .ADC_EOC    (ADC_EOC),
    .ADC_DOUT   (ADC_DOUT),
    .ADC_SOC    (ADC_SOC),
    .ADC_PI     (ADC_PI),
    .APP_DONE   (APP_DONE),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  // Counts SOC-high cycles and any SOC level lasting more than one cycle.
  always @(posedge CLK) begin
    if (ADC_SOC === 1'b1) soc_count++;
    if (ADC_SOC === 1'b1 && soc_prev === 1'b1) soc_wide++;
    soc_prev = ADC_SOC;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_soc(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ADC_SOC === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // Entered in the SOC cycle; answers after dly idle WAIT cycles.
  task automatic conv(input logic [9:0] v, input int dly, input bit stray);
    if (stray) begin
      ADC_EOC  = 1'b1;
      ADC_DOUT = 10'($urandom);
    end
    tick();
    ADC_EOC = 1'b0;
    repeat (dly) tick();
    ADC_EOC  = 1'b1;
    ADC_DOUT = v;
    tick();
    ADC_EOC  = 1'b0;
    ADC_DOUT = 10'($urandom);
  endtask

  task automatic run_avg(input int n, input logic [9:0] vals[8], input int dly, input bit rnd);
    int sum;
    int soc0;
    int ns;
    int d;
    sum  = 0;
    ns   = 1 << n;
    soc0 = soc_count;
    AVG_SEL   = 2'(n);
    APP_START = 1'b1;
    tick();
    for (int i = 0; i < ns; i++) begin
      if (i == 0) chk("soc_latency", 32'(ADC_SOC), 32'd1);
      else        wait_soc("soc_next");
      d = rnd ? int'($urandom_range(0, 5)) : dly;
      conv(vals[i], d, rnd ? 1'($urandom_range(0, 1)) : 1'b0);
      sum += int'(vals[i]);
    end
    chk("done_early", 32'(APP_DONE), 32'd0);
    tick();
    exp_pi = 10'(sum >> n);
    chk("avg_pi", 32'(ADC_PI), 32'(exp_pi));
    chk("avg_done", 32'(APP_DONE), 32'd1);
    chk("avg_err", 32'(TIMEOUT_ERR), 32'd0);
    chk("soc_pulses", 32'(soc_count - soc0), 32'(ns));
    AVG_SEL = ~AVG_SEL;
    repeat (3) tick();
    chk("hold_pi", 32'(ADC_PI), 32'(exp_pi));
    APP_START = 1'b0;
    tick();
    chk("done_clr", 32'(APP_DONE), 32'd0);
    tick();
  endtask

  initial begin
    logic [9:0] vals[8];
    logic [9:0] pi_before;
    int soc0;

    repeat (3) tick();
    chk("rst_soc", 32'(ADC_SOC), 32'd0);
    chk("rst_pi", 32'(ADC_PI), 32'd0);
    chk("rst_done", 32'(APP_DONE), 32'd0);
    chk("rst_err", 32'(TIMEOUT_ERR), 32'd0);
    RST = 1'b0;
    repeat (2) tick();
    chk("idle_no_soc", 32'(soc_count), 32'd0);

    // single sample, EOC three cycles after SOC
    foreach (vals[i]) vals[i] = 10'd0;
    vals[0] = 10'h155;
    run_avg(0, vals, 2, 1'b0);

    // average of four, truncated
    vals[0] = 10'd100; vals[1] = 10'd101; vals[2] = 10'd102; vals[3] = 10'd104;
    run_avg(2, vals, 1, 1'b0);
    chk("avg4_value", 32'(exp_pi), 32'd101);

    // full scale x8
    foreach (vals[i]) vals[i] = 10'h3FF;
    run_avg(3, vals, 0, 1'b0);

    // timeout
    pi_before = exp_pi;
    AVG_SEL   = 2'd1;
    APP_START = 1'b1;
    tick();
    chk("tmo_soc", 32'(ADC_SOC), 32'd1);
    repeat (255) tick();
    chk("tmo_err_early", 32'(TIMEOUT_ERR), 32'd0);
    chk("tmo_done_early", 32'(APP_DONE), 32'd0);
    tick();
    chk("tmo_err", 32'(TIMEOUT_ERR), 32'd1);
    chk("tmo_done", 32'(APP_DONE), 32'd1);
    chk("tmo_pi", 32'(ADC_PI), 32'(pi_before));
    APP_START = 1'b0;
    tick();
    chk("tmo_done_clr", 32'(APP_DONE), 32'd0);
    chk("tmo_err_sticky", 32'(TIMEOUT_ERR), 32'd1);
    APP_START = 1'b1;
    tick();
    chk("tmo_err_cleared", 32'(TIMEOUT_ERR), 32'd0);
    APP_START = 1'b0;
    repeat (2) tick();

    // abort after two of eight, then a stray EOC
    foreach (vals[i]) vals[i] = 10'($urandom);
    soc0      = soc_count;
    AVG_SEL   = 2'd3;
    APP_START = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      wait_soc("abort_soc");
      conv(vals[i], 1, 1'b0);
    end
    APP_START = 1'b0;
    tick();
    ADC_EOC  = 1'b1;
    ADC_DOUT = 10'h2AA;
    tick();
    ADC_EOC = 1'b0;
    repeat (4) tick();
    chk("abort_socs", 32'(soc_count - soc0), 32'd3);
    chk("abort_done", 32'(APP_DONE), 32'd0);
    chk("abort_pi", 32'(ADC_PI), 32'(exp_pi));
    chk("abort_soc_low", 32'(ADC_SOC), 32'd0);
    foreach (vals[i]) vals[i] = 10'($urandom);
    run_avg(3, vals, 0, 1'b1);

    // randomized runs
    repeat (12) begin
      foreach (vals[i]) vals[i] = 10'($urandom);
      run_avg(int'($urandom_range(0, 3)), vals, 0, 1'b1);
    end

    // reset during WAIT, request held high afterwards
    AVG_SEL   = 2'd2;
    APP_START = 1'b1;
    tick();
    wait_soc("rst_run_soc");
    conv(10'h3FF, 0, 1'b0);
    wait_soc("rst_run_soc2");
    tick();
    RST = 1'b1;
    tick();
    chk("mid_rst_soc", 32'(ADC_SOC), 32'd0);
    chk("mid_rst_pi", 32'(ADC_PI), 32'd0);
    chk("mid_rst_done", 32'(APP_DONE), 32'd0);
    chk("mid_rst_err", 32'(TIMEOUT_ERR), 32'd0);
    RST  = 1'b0;
    soc0 = soc_count;
    repeat (5) tick();
    chk("held_start_no_soc", 32'(soc_count - soc0), 32'd0);
    chk("held_start_no_done", 32'(APP_DONE), 32'd0);
    APP_START = 1'b0;
    tick();
    exp_pi = 10'd0;
    foreach (vals[i]) vals[i] = 10'($urandom);
    run_avg(int'($urandom_range(0, 3)), vals, 0, 1'b1);

    chk("soc_single_cycle", 32'(soc_wide), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
